// File: rtl/neural_network_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : neural_network_sequencer
// Purpose  : Layer sequencer for a 3-layer neural datapath with watchdog/abort.
// Revision : 1.0 - initial release
// ============================================================================
module neural_network_sequencer #(
    parameter int TIMEOUT = 1023,
    parameter int CW      = 10
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        go,
    input  logic        abort,
    input  logic        ann_ready,
    input  logic [7:0]  class_in,
    output logic [1:0]  dp_state,
    output logic        ann_start,
    output logic        ann_hidden,
    output logic        ld1,
    output logic        ld2,
    output logic        busy,
    output logic        done,
    output logic        timeout_err,
    output logic [7:0]  class_out,
    output logic [15:0] infer_cnt
);

    typedef enum logic [3:0] {
        S_IDLE    = 4'd0,
        S_L1_GO   = 4'd1,
        S_L1_WAIT = 4'd2,
        S_L1_LD   = 4'd3,
        S_L2_GO   = 4'd4,
        S_L2_WAIT = 4'd5,
        S_L2_LD   = 4'd6,
        S_OL_GO   = 4'd7,
        S_OL_WAIT = 4'd8,
        S_FIN     = 4'd9,
        S_ERR     = 4'd10
    } state_t;

    localparam logic [CW-1:0] C_WD_LAST = CW'(TIMEOUT - 1);

    state_t        r_state;
    state_t        w_next;
    logic [CW-1:0] r_wd;
    logic          w_in_wait;
    logic          w_ready_ok;
    logic          w_expired;

    // Ready is stale on the first WAIT cycle (watchdog still 0), so it only counts afterwards.
    always_comb begin
        w_next     = r_state;
        w_in_wait  = (r_state == S_L1_WAIT) || (r_state == S_L2_WAIT) || (r_state == S_OL_WAIT);
        w_ready_ok = ann_ready && (r_wd != '0);
        w_expired  = (r_wd == C_WD_LAST);
        if (abort && (r_state != S_IDLE)) begin
            w_next = S_IDLE;
        end else begin
            case (r_state)
                S_IDLE:    if (go) w_next = S_L1_GO;
                S_L1_GO:   w_next = S_L1_WAIT;
                S_L1_WAIT: if (w_ready_ok) w_next = S_L1_LD;
                           else if (w_expired) w_next = S_ERR;
                S_L1_LD:   w_next = S_L2_GO;
                S_L2_GO:   w_next = S_L2_WAIT;
                S_L2_WAIT: if (w_ready_ok) w_next = S_L2_LD;
                           else if (w_expired) w_next = S_ERR;
                S_L2_LD:   w_next = S_OL_GO;
                S_OL_GO:   w_next = S_OL_WAIT;
                S_OL_WAIT: if (w_ready_ok) w_next = S_FIN;
                           else if (w_expired) w_next = S_ERR;
                S_FIN:     w_next = S_IDLE;
                S_ERR:     if (go) w_next = S_IDLE;
                default:   w_next = S_IDLE;
            endcase
        end
    end

    // Outputs are decoded from the next state so they stay aligned with the state register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state     <= S_IDLE;
            r_wd        <= '0;
            dp_state    <= 2'b00;
            ann_start   <= 1'b0;
            ann_hidden  <= 1'b1;
            ld1         <= 1'b0;
            ld2         <= 1'b0;
            busy        <= 1'b0;
            done        <= 1'b0;
            timeout_err <= 1'b0;
            class_out   <= 8'h00;
            infer_cnt   <= 16'h0000;
        end else begin
            r_state    <= w_next;
            r_wd       <= w_in_wait ? (r_wd + CW'(1)) : '0;
            ann_start  <= (w_next == S_L1_GO) || (w_next == S_L2_GO) || (w_next == S_OL_GO);
            ld1        <= (w_next == S_L1_LD);
            ld2        <= (w_next == S_L2_LD);
            done       <= (w_next == S_FIN);
            busy       <= (w_next != S_IDLE);
            ann_hidden <= (w_next == S_L1_GO) || (w_next == S_L1_WAIT) || (w_next == S_L1_LD) ||
                          (w_next == S_L2_GO) || (w_next == S_L2_WAIT) || (w_next == S_L2_LD);
            case (w_next)
                S_L1_GO, S_L1_WAIT, S_L1_LD: dp_state <= 2'b00;
                S_L2_GO, S_L2_WAIT, S_L2_LD: dp_state <= 2'b01;
                S_OL_GO, S_OL_WAIT, S_FIN:   dp_state <= 2'b10;
                default:                     dp_state <= dp_state;
            endcase
            if ((r_state == S_ERR) && go) begin
                timeout_err <= 1'b0;
            end else if (w_next == S_ERR) begin
                timeout_err <= 1'b1;
            end
            if (w_next == S_FIN) begin
                class_out <= class_in;
                if (infer_cnt != 16'hFFFF) begin
                    infer_cnt <= infer_cnt + 16'd1;
                end
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_neural_network_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : tb_neural_network_sequencer
// Purpose  : Directed + randomized self-checking bench using a per-layer delay model.
// Revision : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
module tb_neural_network_sequencer;

    localparam int TIMEOUT = 16;
    localparam int CW      = 5;
    localparam int RES_OK    = 0;
    localparam int RES_ABORT = 1;
    localparam int RES_TOUT  = 2;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        go = 1'b0;
    logic        abort = 1'b0;
    logic        ann_ready = 1'b0;
    logic [7:0]  class_in = 8'h00;
    logic [1:0]  dp_state;
    logic        ann_start;
    logic        ann_hidden;
    logic        ld1;
    logic        ld2;
    logic        busy;
    logic        done;
    logic        timeout_err;
    logic [7:0]  class_out;
    logic [15:0] infer_cnt;

    neural_network_sequencer #(.TIMEOUT(TIMEOUT), .CW(CW)) dut (
        .clk(clk), .rst(rst), .go(go), .abort(abort), .ann_ready(ann_ready),
        .class_in(class_in), .dp_state(dp_state), .ann_start(ann_start),
        .ann_hidden(ann_hidden), .ld1(ld1), .ld2(ld2), .busy(busy), .done(done),
        .timeout_err(timeout_err), .class_out(class_out), .infer_cnt(infer_cnt)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;
    int busy_seen = 0;

    // Reference model state: values that persist between inferences.
    logic [1:0]  m_dp;
    logic [7:0]  m_cls;
    logic [15:0] m_cnt;
    logic        m_terr;

    function automatic logic [32:0] obs();
        return {busy, ann_start, ld1, ld2, done, ann_hidden, dp_state, timeout_err, class_out, infer_cnt};
    endfunction

    task automatic check(input string tag, input logic [32:0] got, input logic [32:0] want);
        n_checks++;
        assert (got === want) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, got, want);
        end
    endtask

    task automatic expect_st(input string tag, input bit b, input bit s, input bit l1,
                             input bit l2, input bit d, input bit h);
        check(tag, obs(), {b, s, l1, l2, d, h, m_dp, m_terr, m_cls, m_cnt});
    endtask

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
        if (busy === 1'b1) busy_seen++;
    endtask

    // One layer: GO, then max(d,2) WAIT cycles (ready counts only from the 2nd), capped by TIMEOUT.
    task automatic run_layer(input int L, input int d, input int abk, output int res);
        int wlen;
        int nwait;
        wlen  = (d < 2) ? 2 : d;
        nwait = (wlen > TIMEOUT) ? TIMEOUT : wlen;
        m_dp  = 2'(L);
        expect_st($sformatf("L%0d_go", L), 1, 1, 0, 0, 0, L < 2);
        ann_ready = (d <= 0);
        tick();
        for (int k = 1; k <= nwait; k++) begin
            expect_st($sformatf("L%0d_wait%0d", L, k), 1, 0, 0, 0, 0, L < 2);
            ann_ready = (k >= d);
            abort     = (k == abk);
            go        = 1'($urandom_range(0, 1));
            tick();
            abort = 1'b0;
            go    = 1'b0;
            if (k == abk) begin
                res = RES_ABORT;
                ann_ready = 1'b0;
                expect_st($sformatf("L%0d_abort_idle", L), 0, 0, 0, 0, 0, 0);
                return;
            end
        end
        if (d > 0) ann_ready = 1'b0;
        if (wlen > TIMEOUT) begin
            m_terr = 1'b1;
            res = RES_TOUT;
            expect_st($sformatf("L%0d_err", L), 1, 0, 0, 0, 0, 0);
        end else begin
            res = RES_OK;
        end
    endtask

    task automatic run_infer(input int d0, input int d1, input int d2, input logic [7:0] cls,
                             input int abl, input int abk);
        int dl[3];
        int res;
        dl[0] = d0; dl[1] = d1; dl[2] = d2;
        class_in = cls;
        go = 1'b1;
        tick();
        go = 1'b0;
        for (int L = 0; L < 3; L++) begin
            run_layer(L, dl[L], (L == abl) ? abk : 0, res);
            if (res == RES_ABORT) return;
            if (res == RES_TOUT) begin
                tick();
                expect_st("err_hold", 1, 0, 0, 0, 0, 0);
                go = 1'b1;
                tick();
                go = 1'b0;
                m_terr = 1'b0;
                expect_st("err_exit_idle", 0, 0, 0, 0, 0, 0);
                return;
            end
            if (L < 2) begin
                expect_st($sformatf("L%0d_ld", L), 1, 0, L == 0, L == 1, 0, 1);
                tick();
            end else begin
                m_cls = cls;
                if (m_cnt != 16'hFFFF) m_cnt = m_cnt + 16'd1;
                expect_st("fin", 1, 0, 0, 0, 1, 0);
                ann_ready = 1'b0;
                tick();
                expect_st("post_fin_idle", 0, 0, 0, 0, 0, 0);
            end
        end
    endtask

    initial begin
        int d0, d1, d2, abl, abk;
        m_dp = 2'b00; m_cls = 8'h00; m_cnt = 16'h0000; m_terr = 1'b0;

        // Reset state, checked while reset is still asserted.
        repeat (2) @(negedge clk);
        check("reset_state", obs(), {1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 2'b00, 1'b0, 8'h00, 16'h0000});
        rst = 1'b1;

        // Abort in IDLE is ignored; the sequencer stays idle.
        abort = 1'b1;
        tick();
        abort = 1'b0;
        expect_st("idle_abort_ignored", 0, 0, 0, 0, 0, 0);

        // Nominal inference: ready 5 cycles after each start.
        run_infer(5, 5, 5, 8'h07, -1, 0);

        // Stale-ready: ready high throughout, 12 busy cycles.
        busy_seen = 0;
        run_infer(0, 0, 0, 8'h3C, -1, 0);
        check("stale_busy_cycles", 33'(busy_seen), 33'(12));

        // Timeout in layer 2.
        run_infer(3, 40, 3, 8'hAA, -1, 0);

        // Abort in the same cycle ready rises in the output layer.
        run_infer(2, 4, 5, 8'h55, 2, 5);

        // Asynchronous reset in the middle of L1_WAIT.
        class_in = 8'h99;
        go = 1'b1;
        tick();
        go = 1'b0;
        ann_ready = 1'b0;
        tick();
        tick();
        #2 rst = 1'b0;
        #1;
        m_dp = 2'b00; m_cls = 8'h00; m_cnt = 16'h0000; m_terr = 1'b0;
        check("async_reset_mid_wait", obs(), {1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 2'b00, 1'b0, 8'h00, 16'h0000});
        @(negedge clk);
        rst = 1'b1;
        run_infer(3, 3, 3, 8'h11, -1, 0);

        // Randomized inferences with occasional timeouts and aborts.
        for (int n = 0; n < 25; n++) begin
            d0 = ($urandom_range(0, 9) == 0) ? 20 : $urandom_range(0, 7);
            d1 = ($urandom_range(0, 9) == 0) ? 20 : $urandom_range(0, 7);
            d2 = ($urandom_range(0, 9) == 0) ? 20 : $urandom_range(0, 7);
            abl = ($urandom_range(0, 4) == 0) ? $urandom_range(0, 2) : -1;
            abk = $urandom_range(1, 6);
            run_infer(d0, d1, d2, 8'($urandom), abl, abk);
            if ($urandom_range(0, 1) == 1) begin
                tick();
                expect_st("idle_gap", 0, 0, 0, 0, 0, 0);
            end
        end

        // Saturation of the inference counter.
        force dut.infer_cnt = 16'hFFFE;
        #1;
        release dut.infer_cnt;
        m_cnt = 16'hFFFE;
        run_infer(2, 2, 2, 8'h21, -1, 0);
        check("sat_first", 33'(infer_cnt), 33'(16'hFFFF));
        run_infer(2, 3, 4, 8'h42, -1, 0);
        check("sat_second", 33'(infer_cnt), 33'(16'hFFFF));

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "simulation time limit reached");
    end

endmodule
`default_nettype wire
